// File: rtl/sensor_level_encoder.sv
// -----------------------------------------------------------------------------
// sensor_level_encoder
//   Converts raw per-sensor ADC samples (rain, seismic, wind, water level) into
//   committed 2-bit severity codes for the detection/priority/LED stage.
//   Each channel applies three rising thresholds, a downward hysteresis margin
//   below the threshold of its current level, and a persistence filter, so a
//   level only changes after PERSIST consecutive accepted samples agree on it.
//
//   Optional feature macro: FAST_ESCALATE_EN
//     defined   -> a candidate of 11 commits on its first accepted sample
//     undefined -> every change, escalation to 11 included, obeys PERSIST
//
// Ports
//   clk           in   rising-edge clock
//   rst_n         in   synchronous reset, active-low
//   sample_valid  in   all four *_smp inputs carry a new sample this cycle
//   rain_smp      in   raw rain-gauge sample      (SAMPLE_W)
//   seis_smp      in   raw seismometer sample     (SAMPLE_W)
//   wind_smp      in   raw anemometer sample      (SAMPLE_W)
//   lvl_smp       in   raw water-level sample     (SAMPLE_W)
//   r1,r0         out  committed rain level        (r1 = MSB)
//   s1,s0         out  committed seismic level
//   w1,w0         out  committed wind level
//   l1,l0         out  committed water-level level
//   level_change  out  one-cycle pulse when any channel commits a new level
// -----------------------------------------------------------------------------
module sensor_level_encoder #(
    parameter int unsigned SAMPLE_W = 8,
    parameter int unsigned TH1      = 64,
    parameter int unsigned TH2      = 128,
    parameter int unsigned TH3      = 192,
    parameter int unsigned HYST     = 8,
    parameter int unsigned PERSIST  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] rain_smp,
    input  logic [SAMPLE_W-1:0] seis_smp,
    input  logic [SAMPLE_W-1:0] wind_smp,
    input  logic [SAMPLE_W-1:0] lvl_smp,
    output logic                r1,
    output logic                r0,
    output logic                s1,
    output logic                s0,
    output logic                w1,
    output logic                w0,
    output logic                l1,
    output logic                l0,
    output logic                level_change
);

    localparam int unsigned NCH   = 4;
    localparam int unsigned CNT_W = 4;

    localparam logic [CNT_W-1:0] PERSIST_C = CNT_W'(PERSIST);

    localparam logic [SAMPLE_W-1:0] TH1_C = SAMPLE_W'(TH1);
    localparam logic [SAMPLE_W-1:0] TH2_C = SAMPLE_W'(TH2);
    localparam logic [SAMPLE_W-1:0] TH3_C = SAMPLE_W'(TH3);

    // Hold-down thresholds for each committed level, clamped at zero.
    localparam logic [SAMPLE_W-1:0] LO1_C = SAMPLE_W'((TH1 > HYST) ? (TH1 - HYST) : 0);
    localparam logic [SAMPLE_W-1:0] LO2_C = SAMPLE_W'((TH2 > HYST) ? (TH2 - HYST) : 0);
    localparam logic [SAMPLE_W-1:0] LO3_C = SAMPLE_W'((TH3 > HYST) ? (TH3 - HYST) : 0);

    // Candidate level for one sample given the channel's committed level.
    function automatic logic [1:0] cand_level(input logic [SAMPLE_W-1:0] smp,
                                              input logic [1:0]          lvl);
        logic [SAMPLE_W-1:0] lo;
        logic                m1;
        logic                m2;
        logic                m3;
        case (lvl)
            2'd1:    lo = LO1_C;
            2'd2:    lo = LO2_C;
            2'd3:    lo = LO3_C;
            default: lo = '0;
        endcase
        // A threshold is met by the plain compare, or stays met through the
        // hysteresis band when it lies at or below the committed level.
        m1 = (smp >= TH1_C) || ((lvl >= 2'd1) && (smp >= lo));
        m2 = (smp >= TH2_C) || ((lvl >= 2'd2) && (smp >= lo));
        m3 = (smp >= TH3_C) || ((lvl == 2'd3) && (smp >= lo));
        return 2'(m1) + 2'(m2) + 2'(m3);
    endfunction

    logic [SAMPLE_W-1:0] smp     [NCH];
    logic [1:0]          level_q [NCH];
    logic [1:0]          level_d [NCH];
    logic [1:0]          pend_q  [NCH];
    logic [1:0]          pend_d  [NCH];
    logic [CNT_W-1:0]    cnt_q   [NCH];
    logic [CNT_W-1:0]    cnt_d   [NCH];
    logic [1:0]          cand    [NCH];
    logic [CNT_W-1:0]    cnt_inc [NCH];
    logic                fast    [NCH];
    logic                commit_c;
    logic                level_change_q;

    assign smp[0] = rain_smp;
    assign smp[1] = seis_smp;
    assign smp[2] = wind_smp;
    assign smp[3] = lvl_smp;

    // Per-channel candidate, persistence and commit decision.
    always_comb begin
        commit_c = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            level_d[i] = level_q[i];
            pend_d[i]  = pend_q[i];
            cnt_d[i]   = cnt_q[i];
            cand[i]    = cand_level(smp[i], level_q[i]);
            cnt_inc[i] = cnt_q[i];
            fast[i]    = 1'b0;

            if (sample_valid) begin
`ifdef FAST_ESCALATE_EN
                fast[i] = (cand[i] == 2'd3) && (level_q[i] != 2'd3);
`endif
                if (cand[i] == level_q[i]) begin
                    cnt_d[i] = '0;
                end else begin
                    if (cand[i] == pend_q[i]) begin
                        // Saturate rather than wrap.
                        cnt_inc[i] = (cnt_q[i] >= PERSIST_C) ? cnt_q[i]
                                                              : CNT_W'(cnt_q[i] + 1'b1);
                    end else begin
                        pend_d[i]  = cand[i];
                        cnt_inc[i] = CNT_W'(1);
                    end

                    if ((cnt_inc[i] >= PERSIST_C) || fast[i]) begin
                        level_d[i] = pend_d[i];
                        cnt_d[i]   = '0;
                        commit_c   = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_inc[i];
                    end
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                level_q[i] <= 2'b00;
                pend_q[i]  <= 2'b00;
                cnt_q[i]   <= '0;
            end
            level_change_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                level_q[i] <= level_d[i];
                pend_q[i]  <= pend_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            level_change_q <= commit_c;
        end
    end

    assign r1 = level_q[0][1];
    assign r0 = level_q[0][0];
    assign s1 = level_q[1][1];
    assign s0 = level_q[1][0];
    assign w1 = level_q[2][1];
    assign w0 = level_q[2][0];
    assign l1 = level_q[3][1];
    assign l0 = level_q[3][0];
    assign level_change = level_change_q;

endmodule
